// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Latency: n/a (types, constants only).
// Backpressure: n/a.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_FRAME   = 2'd1;
  localparam logic [1:0] ERR_SIZE    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Header and data words are both 4 bytes, so one packer serves both.
  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Latency: n/a (signal bundle only).
// Backpressure: none; rx_valid and imem_we are single-cycle strobes.
// Ports: rx_data/rx_valid/rx_ferr from the UART receiver, imem_we/imem_addr/imem_wdata to imem.
// Modports: master = loader (consumes rx_*, drives imem_*), slave = environment.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 10
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ferr;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_data, rx_valid, rx_ferr,
    output imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid, rx_ferr,
    input  imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/loader_byte_packer.sv
// Assembles 4 bytes into a little-endian 32-bit word (used for the header count and data words).
// Latency: word register updated on the load edge; word_nxt/full are combinational with load.
// Backpressure: none; accepts a byte on every cycle load is high.
// Ports: clear (restart at byte 0, zero word), load + byte_in (store byte at current index),
//        word (registered word), word_nxt (word including the byte being loaded), full (4th byte now).
module loader_byte_packer
  import uart_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [31:0] word_nxt,
  output logic        full
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [1:0] idx;

  always_comb begin
    word_nxt = word;
    word_nxt[8*idx +: 8] = byte_in;
  end

  assign full = load && (idx == LAST_IDX);

  // idx wraps 3 -> 0 on its own, so the next word starts at byte 0 without a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx  <= '0;
      word <= '0;
    end else if (clear) begin
      idx  <= '0;
      word <= '0;
    end else if (load) begin
      idx  <= idx + 2'd1;
      word <= word_nxt;
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: parses a 4-byte LE word count then N LE words from the UART and writes them to imem.
// Latency: imem_we rises 1 cycle after the rx_valid of a word's 4th byte; header decision 1 cycle after byte 3.
// Backpressure: none; accepts a byte every cycle, including during the write cycle.
// Ports: clk, reset_n (async active-low), start (arm pulse), bus (rx in / imem write out),
//        busy/done/err levels, err_code (held while err), words_loaded (words written this load).
module uart_prog_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  uart_prog_loader_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  // Idle counter only needs to reach TIMEOUT_CYC-1: the expiry is taken on the following edge.
  localparam int              TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0]   TO_LAST = TW'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
  localparam logic [ADDR_W:0] CAP     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  state_t            state;
  logic              hdr_chk;      // header complete, decide on next cycle
  logic [ADDR_W:0]   n_words;
  logic [TW-1:0]     tcnt;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;

  logic              in_load;
  logic              arm;
  logic              byte_err;
  logic              pk_load;
  logic              pk_full;
  logic [31:0]       pk_word;
  logic [31:0]       pk_word_nxt;
  logic              tmo;
  logic              hdr_zero;
  logic              hdr_big;
  logic [ADDR_W:0]   wl_inc;

  assign in_load  = (state == HDR) || (state == DATA) || (state == WRITE);
  assign arm      = start && !in_load;
  assign byte_err = bus.rx_valid && bus.rx_ferr;
  // Bytes outside a load are dropped; errored bytes never reach the packer.
  assign pk_load  = in_load && bus.rx_valid && !bus.rx_ferr;

  assign tmo      = (TIMEOUT_CYC != 0) && !bus.rx_valid && (tcnt == TO_LAST);

  // Count is valid only if it fits in ADDR_W+1 bits and does not exceed the imem capacity.
  assign hdr_zero = (pk_word == 32'd0);
  assign hdr_big  = (|pk_word[31:ADDR_W+1]) || (pk_word[ADDR_W:0] > CAP);
  assign wl_inc   = words_loaded + (ADDR_W+1)'(1);

  loader_byte_packer u_packer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (arm),
    .load     (pk_load),
    .byte_in  (bus.rx_data),
    .word     (pk_word),
    .word_nxt (pk_word_nxt),
    .full     (pk_full)
  );

  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      hdr_chk      <= 1'b0;
      n_words      <= '0;
      tcnt         <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      words_loaded <= '0;
    end else begin
      imem_we_q <= 1'b0;

      if (arm || bus.rx_valid) begin
        tcnt <= '0;
      end else if (in_load && (TIMEOUT_CYC != 0)) begin
        tcnt <= tcnt + TW'(1);
      end

      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= HDR;
            hdr_chk      <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
            words_loaded <= '0;
          end
        end

        HDR: begin
          if (byte_err) begin
            state    <= ERR;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_FRAME;
          end else if (hdr_chk) begin
            // A byte arriving in this cycle is already in the packer as data byte 0.
            hdr_chk <= 1'b0;
            if (hdr_zero) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (hdr_big) begin
              state    <= ERR;
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= ERR_SIZE;
            end else begin
              n_words <= pk_word[ADDR_W:0];
              state   <= DATA;
            end
          end else if (pk_full) begin
            hdr_chk <= 1'b1;
          end else if (tmo) begin
            state    <= ERR;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end
        end

        DATA: begin
          if (byte_err) begin
            state    <= ERR;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_FRAME;
          end else if (pk_full) begin
            state        <= WRITE;
            imem_we_q    <= 1'b1;
            imem_addr_q  <= BASE + words_loaded[ADDR_W-1:0];
            imem_wdata_q <= pk_word_nxt;
          end else if (tmo) begin
            state    <= ERR;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end
        end

        WRITE: begin
          words_loaded <= wl_inc;
          if (wl_inc == n_words) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (byte_err) begin
            state    <= ERR;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_FRAME;
          end else begin
            state <= DATA;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: randomized loads against a list-based expectation model.
// Latency: checks imem_we on the cycle after each word's 4th byte and header decision one cycle later.
// Backpressure: n/a (bench drives bytes at random gaps and back-to-back).
module tb_uart_prog_loader;

  localparam int AW   = 4;
  localparam int BASE = 0;
  localparam int TO   = 100;
  localparam int CAP  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [AW:0]   words_loaded;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;

  uart_prog_loader_if #(.ADDR_W(AW)) bus ();

  uart_prog_loader #(.ADDR_W(AW), .BASE_ADDR(BASE), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.imem_we === 1'b1) wr_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, want summary before 2ms");
    $fatal(1);
  end

  // All tasks are entered and left at a negedge.
  task automatic send_byte(input logic [7:0] b, input logic f);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    bus.rx_ferr  = f;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_ferr  = 1'b0;
  endtask

  // Idle cycles with noise on rx_data/rx_ferr; rx_ferr without rx_valid must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.rx_ferr = 1'($urandom_range(0, 1));
      bus.rx_data = 8'($urandom);
      @(negedge clk);
    end
    bus.rx_ferr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Model: count N; N==0 -> done, N>CAP -> size error, else word i lands at (BASE+i) mod CAP.
  task automatic do_load(input logic [31:0] hdr, input logic [31:0] words[$], input int gap_max,
                         input bit do_start, input string tag);
    bit ok_size;
    int n_exp;
    int w0;
    ok_size = (hdr <= 32'(CAP));
    n_exp   = ok_size ? int'(hdr) : 0;
    w0      = wr_cnt;
    if (do_start) begin
      pulse_start();
      idle($urandom_range(0, gap_max));
    end
    for (int b = 0; b < 4; b++) begin
      send_byte(hdr[8*b +: 8], 1'b0);
      idle($urandom_range(0, gap_max));
    end
    for (int i = 0; i < n_exp; i++) begin
      for (int b = 0; b < 4; b++) begin
        send_byte(words[i][8*b +: 8], 1'b0);
        if (b == 3) begin
          n_checks++;
          if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, AW'(BASE + i), words[i]}) begin
            n_fail++;
            $display("FAIL %s write%0d: got we=%b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                     tag, i, bus.imem_we, bus.imem_addr, bus.imem_wdata, AW'(BASE + i), words[i]);
          end
        end
        idle($urandom_range(0, gap_max));
      end
    end
    idle(3);
    n_checks++;
    if ({busy, done, err, err_code} !== {1'b0, ok_size, !ok_size, ok_size ? 2'd0 : 2'd2}) begin
      n_fail++;
      $display("FAIL %s status: got busy=%b done=%b err=%b code=%0d, want busy=0 done=%b err=%b code=%0d",
               tag, busy, done, err, err_code, ok_size, !ok_size, ok_size ? 0 : 2);
    end
    n_checks++;
    if (words_loaded !== (AW+1)'(n_exp)) begin
      n_fail++;
      $display("FAIL %s words_loaded: got %0d, want %0d", tag, words_loaded, n_exp);
    end
    n_checks++;
    if (wr_cnt - w0 !== n_exp) begin
      n_fail++;
      $display("FAIL %s write count: got %0d, want %0d", tag, wr_cnt - w0, n_exp);
    end
  endtask

  task automatic test_reset();
    bus.rx_valid = 1'b0;
    bus.rx_ferr  = 1'b0;
    bus.rx_data  = 8'h00;
    #3 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, err, err_code, words_loaded, bus.imem_we, bus.imem_addr, bus.imem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got busy=%b done=%b err=%b code=%0d wl=%0d we=%b, want all 0",
               busy, done, err, err_code, words_loaded, bus.imem_we);
    end
    reset_n = 1'b1;
    // Bytes while idle are dropped.
    for (int i = 0; i < 8; i++) begin
      send_byte(8'($urandom), 1'b0);
      idle($urandom_range(0, 1));
    end
    idle(2);
    n_checks++;
    if ({busy, done, err, err_code, words_loaded, bus.imem_we} !== '0 || wr_cnt !== 0) begin
      n_fail++;
      $display("FAIL idle_drop: got busy=%b done=%b err=%b wl=%0d writes=%0d, want all 0",
               busy, done, err, words_loaded, wr_cnt);
    end
  endtask

  task automatic test_basic();
    logic [31:0] q[$];
    q.push_back(32'h12345678);
    q.push_back(32'hDEADBEEF);
    do_load(32'd2, q, 2, 1'b1, "basic");
  endtask

  task automatic test_zero();
    int w0;
    w0 = wr_cnt;
    pulse_start();
    for (int b = 0; b < 4; b++) send_byte(8'h00, 1'b0);
    n_checks++;
    if ({busy, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL zero_decide_early: got busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    idle(1);
    n_checks++;
    if ({busy, done, err, words_loaded} !== {3'b010, (AW+1)'(0)}) begin
      n_fail++;
      $display("FAIL zero_done: got busy=%b done=%b err=%b wl=%0d, want 0 1 0 0", busy, done, err, words_loaded);
    end
    idle(3);
    n_checks++;
    if (wr_cnt - w0 !== 0) begin
      n_fail++;
      $display("FAIL zero_writes: got %0d, want 0", wr_cnt - w0);
    end
  endtask

  task automatic test_size();
    logic [31:0] q[$];
    do_load(32'd17, q, 1, 1'b1, "size17");
    do_load(32'h0001_0001, q, 1, 1'b1, "size_upper");
    for (int i = 0; i < CAP; i++) q.push_back($urandom);
    do_load(32'(CAP), q, 2, 1'b1, "size_full");
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    int n;
    for (int r = 0; r < 4; r++) begin
      q.delete();
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) q.push_back($urandom);
      do_load(32'(n), q, 3, 1'b1, "random");
    end
  endtask

  task automatic test_ferr();
    logic [31:0] w;
    logic [31:0] q[$];
    int w0;
    w  = $urandom;
    w0 = wr_cnt;
    pulse_start();
    for (int b = 0; b < 4; b++) send_byte(b == 0 ? 8'd3 : 8'd0, 1'b0);
    idle(1);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b0);
    n_checks++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, AW'(BASE), w}) begin
      n_fail++;
      $display("FAIL ferr word0: got we=%b addr=%0d data=%h, want 1 %0d %h", bus.imem_we, bus.imem_addr, bus.imem_wdata, BASE, w);
    end
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    idle(2);
    for (int b = 0; b < 5; b++) send_byte(8'($urandom), 1'b0);
    idle(2);
    n_checks++;
    if ({busy, done, err, err_code, words_loaded} !== {3'b001, 2'd1, (AW+1)'(1)} || wr_cnt - w0 !== 1) begin
      n_fail++;
      $display("FAIL ferr status: got busy=%b done=%b err=%b code=%0d wl=%0d writes=%0d, want 0 0 1 1 1 1",
               busy, done, err, err_code, words_loaded, wr_cnt - w0);
    end
    pulse_start();
    n_checks++;
    if ({busy, done, err, err_code, words_loaded} !== {3'b100, 2'd0, (AW+1)'(0)}) begin
      n_fail++;
      $display("FAIL ferr rearm: got busy=%b done=%b err=%b code=%0d wl=%0d, want 1 0 0 0 0",
               busy, done, err, err_code, words_loaded);
    end
    q.push_back($urandom);
    do_load(32'd1, q, 1, 1'b0, "ferr_rearm");
  endtask

  task automatic test_timeout();
    pulse_start();
    idle(TO - 1);
    n_checks++;
    if ({busy, err} !== 2'b10) begin
      n_fail++;
      $display("FAIL tmo_hdr_early: got busy=%b err=%b, want 1 0", busy, err);
    end
    idle(1);
    n_checks++;
    if ({busy, err, err_code} !== {2'b01, 2'd3}) begin
      n_fail++;
      $display("FAIL tmo_hdr: got busy=%b err=%b code=%0d, want 0 1 3", busy, err, err_code);
    end
    pulse_start();
    for (int b = 0; b < 4; b++) begin
      send_byte(b == 0 ? 8'd2 : 8'd0, 1'b0);
      idle(2);
    end
    send_byte(8'hA5, 1'b0);
    idle(5);
    send_byte(8'h5A, 1'b0);
    idle(TO - 1);
    n_checks++;
    if ({busy, err} !== 2'b10) begin
      n_fail++;
      $display("FAIL tmo_data_early: got busy=%b err=%b, want 1 0", busy, err);
    end
    idle(1);
    n_checks++;
    if ({busy, err, err_code, words_loaded} !== {2'b01, 2'd3, (AW+1)'(0)}) begin
      n_fail++;
      $display("FAIL tmo_data: got busy=%b err=%b code=%0d wl=%0d, want 0 1 3 0", busy, err, err_code, words_loaded);
    end
  endtask

  task automatic test_start_busy();
    logic [31:0] w;
    w = $urandom;
    pulse_start();
    for (int b = 0; b < 4; b++) send_byte(b == 0 ? 8'd1 : 8'd0, 1'b0);
    send_byte(w[7:0], 1'b0);
    send_byte(w[15:8], 1'b0);
    pulse_start();
    send_byte(w[23:16], 1'b0);
    send_byte(w[31:24], 1'b0);
    n_checks++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, AW'(BASE), w}) begin
      n_fail++;
      $display("FAIL start_busy write: got we=%b addr=%0d data=%h, want 1 %0d %h", bus.imem_we, bus.imem_addr, bus.imem_wdata, BASE, w);
    end
    idle(2);
    n_checks++;
    if ({busy, done, err, words_loaded} !== {3'b010, (AW+1)'(1)}) begin
      n_fail++;
      $display("FAIL start_busy status: got busy=%b done=%b err=%b wl=%0d, want 0 1 0 1", busy, done, err, words_loaded);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] w;
    int w1;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    // start and a byte together in IDLE: byte dropped, start honoured.
    bus.rx_data  = 8'hAA;
    bus.rx_valid = 1'b1;
    start        = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    start        = 1'b0;
    for (int i = 0; i < 3; i++) q.push_back($urandom);
    do_load(32'd3, q, 0, 1'b0, "b2b");
    // Reset while a write strobe is high, with bytes still streaming.
    w = $urandom;
    pulse_start();
    for (int b = 0; b < 4; b++) send_byte(b == 0 ? 8'd3 : 8'd0, 1'b0);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b0);
    n_checks++;
    if (bus.imem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_pre_reset we: got %b, want 1", bus.imem_we);
    end
    bus.rx_data  = 8'($urandom);
    bus.rx_valid = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, err, err_code, words_loaded, bus.imem_we, bus.imem_addr, bus.imem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset outputs: got busy=%b done=%b err=%b wl=%0d we=%b, want all 0",
               busy, done, err, words_loaded, bus.imem_we);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.rx_data = 8'($urandom);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    reset_n = 1'b1;
    w1 = wr_cnt;
    for (int i = 0; i < 12; i++) send_byte(8'($urandom), 1'b0);
    idle(3);
    n_checks++;
    if ({busy, done, err, err_code, words_loaded} !== '0 || wr_cnt !== w1) begin
      n_fail++;
      $display("FAIL post_reset idle: got busy=%b done=%b err=%b wl=%0d writes=%0d, want all 0",
               busy, done, err, words_loaded, wr_cnt - w1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_size();
    test_random();
    test_ferr();
    test_timeout();
    test_start_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
